// File: rtl/sad_pkg.sv
// sad_pkg: default geometry of the SAD datapath and the accumulator width rule.
package sad_pkg;
    localparam int N = 256;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int SUM_W = 16;
    // N loads of a DATA_W magnitude fit in DATA_W+ADDR_W bits without wrapping.
    function automatic bit sum_w_ok(int sum_w, int data_w, int addr_w);
        return sum_w >= data_w + addr_w;
    endfunction
    localparam bit SUM_W_OK = sum_w_ok(SUM_W, DATA_W, ADDR_W);
endpackage

// File: rtl/sad_absdiff.sv
// sad_absdiff: combinational |a - b| for unsigned operands.
module sad_absdiff #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W:0] diff;
    logic [DATA_W:0] neg;
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        neg = -diff;
        y = diff[DATA_W] ? neg[DATA_W-1:0] : diff[DATA_W-1:0];
    end
endmodule

// File: rtl/sad_datapath.sv
// sad_datapath: index counter, |A-B| accumulator and SAD result register
// driven by the strobes of the SAD controller.
module sad_datapath
    import sad_pkg::*;
#(
    parameter int N = sad_pkg::N,
    parameter int DATA_W = sad_pkg::DATA_W,
    parameter int ADDR_W = sad_pkg::ADDR_W,
    parameter int SUM_W = sad_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              sum_clr,
    input  logic              sum_ld,
    input  logic              AB_rd,
    input  logic              sadreg_clr,
    input  logic              sadreg_ld,
    input  logic [DATA_W-1:0] A_data,
    input  logic [DATA_W-1:0] B_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              i_lt_256,
    output logic [SUM_W-1:0]  sad,
    output logic              sad_valid
);
    localparam logic [ADDR_W:0] I_MAX = (ADDR_W+1)'(N);

    if (!sum_w_ok(SUM_W, DATA_W, ADDR_W)) begin : g_width_check
        $error("sad_datapath: SUM_W must be at least DATA_W + ADDR_W");
    end

    logic [ADDR_W:0]   i;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] ad;

    sad_absdiff #(.DATA_W(DATA_W)) u_absdiff (
        .a(A_data),
        .b(B_data),
        .y(ad)
    );

    always_comb begin
        mem_addr = i[ADDR_W-1:0];
        mem_rd = AB_rd;
        i_lt_256 = i < I_MAX;
    end

    // Clears win over loads everywhere; sad captures sum before this edge's load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i <= '0;
            sum <= '0;
            sad <= '0;
            sad_valid <= 1'b0;
        end else begin
            if (i_clr)
                i <= '0;
            else if (i_inc && i != I_MAX)
                i <= i + (ADDR_W+1)'(1);
            if (sum_clr)
                sum <= '0;
            else if (sum_ld)
                sum <= sum + SUM_W'(ad);
            if (sadreg_clr)
                sad <= '0;
            else if (sadreg_ld)
                sad <= sum;
            if (sadreg_clr || sum_clr)
                sad_valid <= 1'b0;
            else if (sadreg_ld)
                sad_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sad_datapath.sv
// tb_sad_datapath: scoreboard bench; the driver queues expected SADs and
// status snapshots, a negedge monitor compares them against the DUT.
module tb_sad_datapath;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld;
    logic [7:0] A_data, B_data, mem_addr;
    logic mem_rd, i_lt_256, sad_valid;
    logic [15:0] sad;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int sad;
        int valid;
        int lt;
        int addr;
        int rd;
    } snap_t;

    snap_t snap_q[$];
    int sad_q[$];
    logic prev_valid = 1'b0;

    sad_datapath dut (
        .clk(clk),
        .rst(rst),
        .i_clr(i_clr),
        .i_inc(i_inc),
        .sum_clr(sum_clr),
        .sum_ld(sum_ld),
        .AB_rd(AB_rd),
        .sadreg_clr(sadreg_clr),
        .sadreg_ld(sadreg_ld),
        .A_data(A_data),
        .B_data(B_data),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .i_lt_256(i_lt_256),
        .sad(sad),
        .sad_valid(sad_valid)
    );

    always #5 clk = ~clk;

    assign A_data = mem_a[mem_addr];
    assign B_data = mem_b[mem_addr];

    function automatic void chk(string n, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, got, exp);
        end
    endfunction

    // Reference: SAD of the whole memory image, reduced to 16 bits.
    function automatic int ref_sad();
        int t = 0;
        for (int k = 0; k < 256; k++)
            t += (mem_a[k] > mem_b[k]) ? int'(mem_a[k]) - int'(mem_b[k]) : int'(mem_b[k]) - int'(mem_a[k]);
        return t % 65536;
    endfunction

    always @(negedge clk) begin
        snap_t s;
        if (sad_valid && !prev_valid) begin
            if (sad_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: sad=%0d presented with nothing expected", sad);
            end else
                chk("result_sad", int'(sad), sad_q.pop_front());
        end
        prev_valid = sad_valid;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            if (s.sad >= 0)
                chk({s.name, "_sad"}, int'(sad), s.sad);
            chk({s.name, "_valid"}, int'(sad_valid), s.valid);
            chk({s.name, "_lt"}, int'(i_lt_256), s.lt);
            chk({s.name, "_addr"}, int'(mem_addr), s.addr);
            chk({s.name, "_rd"}, int'(mem_rd), s.rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld} = 7'b0;
    endtask

    task automatic snap(string n, int s, int v, int l, int a);
        snap_t e;
        e.name = n;
        e.sad = s;
        e.valid = v;
        e.lt = l;
        e.addr = a;
        e.rd = int'(AB_rd);
        snap_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic load_expect(int exp);
        idle();
        sadreg_ld = 1'b1;
        sad_q.push_back(exp);
        step();
        idle();
        step();
    endtask

    task automatic run_block(string tag);
        int exp;
        exp = ref_sad();
        idle();
        i_clr = 1'b1;
        sum_clr = 1'b1;
        step();
        idle();
        AB_rd = 1'b1;
        sum_ld = 1'b1;
        i_inc = 1'b1;
        repeat (255) step();
        snap({tag, "_e254"}, -1, 0, 1, 255);
        step();
        idle();
        snap({tag, "_end"}, -1, 0, 0, 0);
        load_expect(exp);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'(k);
            mem_b[k] = 8'(255 - k);
        end
    endtask

    initial begin
        int pre;
        fill_ramp();
        {i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld} = 7'h7f;
        step();
        step();
        snap("reset", 0, 0, 1, 0);
        rst = 1'b1;
        idle();
        step();

        run_block("ramp");
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'($urandom);
            mem_b[k] = 8'($urandom);
        end
        run_block("random");
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'd255;
            mem_b[k] = 8'd0;
        end
        run_block("max");

        // i sits at N, so extra loads keep reading element 0 and the sum wraps.
        idle();
        sadreg_clr = 1'b1;
        step();
        idle();
        AB_rd = 1'b1;
        sum_ld = 1'b1;
        repeat (2) step();
        load_expect((256 * 255 + 2 * 255) % 65536);

        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'd0;
            mem_b[k] = 8'd255;
        end
        run_block("max_swap");
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'($urandom);
            mem_b[k] = mem_a[k];
        end
        run_block("equal");

        idle();
        i_clr = 1'b1;
        step();
        idle();
        i_inc = 1'b1;
        repeat (260) step();
        idle();
        snap("saturate", 0, 1, 0, 0);

        i_clr = 1'b1;
        step();
        idle();
        i_inc = 1'b1;
        repeat (5) step();
        idle();
        snap("inc5", 0, 1, 1, 5);
        i_clr = 1'b1;
        i_inc = 1'b1;
        step();
        idle();
        snap("iclr_pri", 0, 1, 1, 0);

        mem_a[0] = 8'd100;
        mem_b[0] = 8'd0;
        mem_a[1] = 8'd10;
        mem_b[1] = 8'd15;
        sum_clr = 1'b1;
        step();
        idle();
        sum_ld = 1'b1;
        step();
        idle();
        sum_clr = 1'b1;
        sum_ld = 1'b1;
        step();
        load_expect(0);

        sum_clr = 1'b1;
        i_clr = 1'b1;
        step();
        idle();
        sum_ld = 1'b1;
        i_inc = 1'b1;
        step();
        idle();
        sum_ld = 1'b1;
        sadreg_ld = 1'b1;
        sad_q.push_back(100);
        step();
        idle();
        step();
        sadreg_clr = 1'b1;
        step();
        idle();
        snap("sadreg_clr", 0, 0, 1, 1);
        load_expect(105);
        sadreg_clr = 1'b1;
        sadreg_ld = 1'b1;
        step();
        idle();
        snap("sadreg_pri", 0, 0, 1, 1);

        fill_ramp();
        pre = ref_sad();
        run_block("pre_abort");
        idle();
        i_clr = 1'b1;
        sum_clr = 1'b1;
        step();
        idle();
        AB_rd = 1'b1;
        sum_ld = 1'b1;
        i_inc = 1'b1;
        repeat (100) step();
        snap("mid_run", pre, 0, 1, 100);
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle();
        snap("abort", 0, 0, 1, 0);
        run_block("post_abort");

        repeat (3) step();
        checks++;
        if (sad_q.size() != 0) begin
            errors++;
            $display("FAIL results_drained: %0d results still pending, expected 0", sad_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary within the time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sad_datapath.md
# sad_datapath

Datapath stage that consumes the control strobes of the SAD controller (`SAD_FSM`) and computes the sum of absolute differences between two N-element blocks, A and B. It holds the element index counter, drives the A/B memory address and read enable, accumulates |A[i]−B[i]|, and latches the final SAD. It returns `i_lt_256` to the controller, closing the control loop.

## Interface
- `N`, 256: elements per block; power of two.
- `DATA_W`, 8: element width, unsigned.
- `ADDR_W`, 8: memory address width, log2(N).
- `SUM_W`, 16: accumulator and SAD width; must be ≥ DATA_W + ADDR_W.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled only on the `clk` rising edge.
- `i_clr`  in  1  clear index counter.
- `i_inc`  in  1  increment index counter.
- `sum_clr`  in  1  clear accumulator.
- `sum_ld`  in  1  accumulate the current |A−B|.
- `AB_rd`  in  1  read strobe for the A/B memories.
- `sadreg_clr`  in  1  clear SAD register and `sad_valid`.
- `sadreg_ld`  in  1  load SAD register from the accumulator.
- `A_data`  in  DATA_W  A memory read data; combinational in `mem_addr`.
- `B_data`  in  DATA_W  B memory read data; combinational in `mem_addr`.
- `mem_addr`  out  ADDR_W  `i[ADDR_W-1:0]`.
- `mem_rd`  out  1  equals `AB_rd`; combinational passthrough.
- `i_lt_256`  out  1  high when i < N; combinational from `i`.
- `sad`  out  SUM_W  SAD register.
- `sad_valid`  out  1  high while `sad` holds a completed result.

## Operation
- Index counter `i` has ADDR_W+1 bits.
  - `i_clr` → 0.
  - Else `i_inc` → i+1, saturating at N; `i_inc` at i==N holds N.
- Accumulator `sum` has SUM_W bits.
  - `sum_clr` → 0.
  - Else `sum_ld` → sum + |A_data − B_data|.
  - Difference is computed unsigned at DATA_W+1 bits, then magnitude taken; result is zero-extended to SUM_W.
  - With the width rule, no overflow is possible within N loads. Loads beyond N wrap modulo 2^SUM_W; no error is flagged.
- SAD register:
  - `sadreg_clr` → `sad`=0, `sad_valid`=0.
  - Else `sadreg_ld` → `sad` takes the pre-edge value of `sum`, `sad_valid`=1.
- `sum_clr` also drops `sad_valid`, so a new computation invalidates the old result; `sad` keeps its value.
- Simultaneous strobes:
  - Clear beats load/increment in every register.
  - `sum_ld` and `i_inc` in the same cycle use the pre-edge `i` for the address.
  - `sadreg_ld` with `sum_ld` captures the pre-edge `sum`, excluding the current element.
- `sum_ld` is honoured regardless of `AB_rd`. Keeping them paired is the controller's job.
- No state machine in this block. All sequencing belongs to `SAD_FSM`; this block is registers plus combinational logic.

## Timing
- Reset (`rst`=0 at an edge): i=0, sum=0, sad=0, sad_valid=0. After reset, `i_lt_256`=1, `mem_addr`=0, `mem_rd` follows `AB_rd`.
- Reset mid-computation aborts it on that edge; all strobes are ignored that cycle.
- `mem_addr` and `i_lt_256` change one cycle after the `i_inc`/`i_clr` edge.
- Memory read is zero-latency: A/B data for `mem_addr` is sampled on the same edge as `sum_ld`.
- Full block: N cycles with `sum_ld`+`i_inc` asserted, then `sadreg_ld`.
  - `sad` and `sad_valid` are visible the cycle after the `sadreg_ld` edge.
  - `i_lt_256` falls the cycle after the Nth `i_inc`.

## Structure
- Package `sad_pkg`: `N`, `DATA_W`, `ADDR_W`, `SUM_W` defaults, plus an elaboration-time check of SUM_W ≥ DATA_W+ADDR_W.
- Sub-module `sad_absdiff`: combinational, DATA_W in ×2, DATA_W out, |a−b|.
- Top-level instantiation pairs `sad_datapath` with `SAD_FSM` in a `sad_top` wrapper, outside this block.

## Test plan
- Reset: hold `rst`=0 two cycles with all strobes high → i=0, sum=0, sad=0, sad_valid=0, `i_lt_256`=1.
- Full run: A[k]=k, B[k]=255−k over 256 elements with the standard strobe sequence → sad=32768, sad_valid=1; `i_lt_256`=0 after element 255.
- Extremes: A all 255, B all 0 → sad=65280 with no wrap. Swap A/B → same result. A==B → sad=0.
- Priority: `i_clr`+`i_inc`, `sum_clr`+`sum_ld`, and `sadreg_clr`+`sadreg_ld` each asserted together → the register clears. `sum_ld`+`sadreg_ld` at sum=100 with |A−B|=5 → sad=100, sum=105.
- Saturation: 260 `i_inc` pulses → i holds 256 and `mem_addr`=0. Extra `sum_ld` wraps the sum modulo 2^16.
- Abort: `rst` low at element 100 → all state cleared next cycle. A fresh run then yields the correct SAD, and `sad_valid` stays low until its `sadreg_ld`.
